// File: rtl/ecdsa_pkg.sv
// Shared constants for the ECDSA command path: CSR map, STATUS bits, word geometry, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ecdsa_pkg;

    // CSR byte offsets within the AXI-lite register bank (STATUS is the read view of offset 0)
    localparam logic [7:0] CSR_COMMAND = 8'h00;
    localparam logic [7:0] CSR_RXADDR  = 8'h04;
    localparam logic [7:0] CSR_TXADDR  = 8'h08;
    localparam logic [7:0] CSR_STATUS  = 8'h00;

    // STATUS bit positions
    localparam int DONE_BIT = 0;
    localparam int BUSY_BIT = 1;

    // One BRAM word is 1024 bits = 128 bytes; word addresses are 128-byte aligned
    localparam int WORD_BYTES = 128;
    localparam int WORD_SHIFT = $clog2(WORD_BYTES);

    // Sequencer states
    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_RD_REQ    = 3'd1;
    localparam logic [2:0] S_RD_WAIT   = 3'd2;
    localparam logic [2:0] S_PUSH      = 3'd3;
    localparam logic [2:0] S_START     = 3'd4;
    localparam logic [2:0] S_WAIT_CORE = 3'd5;
    localparam logic [2:0] S_WRITE     = 3'd6;
    localparam logic [2:0] S_DONE      = 3'd7;

endpackage

// File: rtl/ecdsa_cmd_ctrl.sv
// Sequencer: fetch N_IN operand words from BRAM, stream them to the ECDSA core, start it, write the result back.
// Latency: N_IN*(RD_LAT+2)+3 cycles from the start edge to STATUS.done, plus core compute time.
// Backpressure: op_valid/op_data hold while op_ready is low; no further BRAM read is issued until the word is taken.
module ecdsa_cmd_ctrl
    import ecdsa_pkg::*;
#(
    parameter int DATA_W = 1024,
    parameter int ADDR_W = 17,
    parameter int N_IN   = 4,
    parameter int RD_LAT = 1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           cmd_reg,
    input  logic [31:0]           rxaddr_reg,
    input  logic [31:0]           txaddr_reg,
    output logic [31:0]           status_reg,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_din,
    input  logic [DATA_W-1:0]     mem_dout,
    output logic [DATA_W/8-1:0]   mem_we,
    output logic [DATA_W-1:0]     op_data,
    output logic                  op_valid,
    input  logic                  op_ready,
    output logic                  core_start,
    input  logic                  core_done,
    input  logic [DATA_W-1:0]     core_result
);

    logic [2:0]          state_q, state_d;
    logic                cmd_prev_q;
    logic [ADDR_W-1:0]   rx_base_q, rx_base_d;
    logic [ADDR_W-1:0]   tx_base_q, tx_base_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [1:0]          lat_q, lat_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_din_q, mem_din_d;
    logic [DATA_W/8-1:0] mem_we_q, mem_we_d;
    logic [DATA_W-1:0]   op_data_q, op_data_d;
    logic                op_valid_q, op_valid_d;
    logic                core_start_q, core_start_d;

    logic                start_edge;
    logic [3:0]          cnt_nxt;
    logic [ADDR_W-1:0]   rx_aligned;
    logic [ADDR_W-1:0]   tx_aligned;
    logic                unused_csr_bits;

    // Only bit0 of COMMAND and the word-aligned in-range address bits carry meaning
    assign rx_aligned = {rxaddr_reg[ADDR_W-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};
    assign tx_aligned = {txaddr_reg[ADDR_W-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};
    assign unused_csr_bits = ^{cmd_reg[31:1],
                               rxaddr_reg[31:ADDR_W], rxaddr_reg[WORD_SHIFT-1:0],
                               txaddr_reg[31:ADDR_W], txaddr_reg[WORD_SHIFT-1:0]};

    assign start_edge = cmd_reg[0] & ~cmd_prev_q;
    assign cnt_nxt    = cnt_q + 4'd1;

    // Next-state and registered-output computation; outputs are loaded on the transition into their state
    always_comb begin
        state_d      = state_q;
        rx_base_d    = rx_base_q;
        tx_base_d    = tx_base_q;
        cnt_d        = cnt_q;
        lat_d        = lat_q;
        mem_addr_d   = mem_addr_q;
        mem_din_d    = mem_din_q;
        mem_we_d     = '0;
        op_data_d    = op_data_q;
        op_valid_d   = op_valid_q;
        core_start_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_edge) begin
                    rx_base_d  = rx_aligned;
                    tx_base_d  = tx_aligned;
                    cnt_d      = 4'd0;
                    lat_d      = 2'd0;
                    mem_addr_d = rx_aligned;
                    state_d    = S_RD_REQ;
                end
            end
            S_RD_REQ: begin
                lat_d   = 2'd0;
                state_d = S_RD_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == 2'(RD_LAT - 1)) begin
                    op_data_d  = mem_dout;
                    op_valid_d = 1'b1;
                    state_d    = S_PUSH;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            S_PUSH: begin
                if (op_ready) begin
                    op_valid_d = 1'b0;
                    cnt_d      = cnt_nxt;
                    if (cnt_nxt < 4'(N_IN)) begin
                        // Address arithmetic wraps naturally at ADDR_W bits
                        mem_addr_d = rx_base_q + (ADDR_W'(cnt_nxt) << WORD_SHIFT);
                        state_d    = S_RD_REQ;
                    end else begin
                        core_start_d = 1'b1;
                        state_d      = S_START;
                    end
                end
            end
            S_START: begin
                state_d = S_WAIT_CORE;
            end
            S_WAIT_CORE: begin
                if (core_done) begin
                    mem_din_d  = core_result;
                    mem_addr_d = tx_base_q;
                    mem_we_d   = '1;
                    state_d    = S_WRITE;
                end
            end
            S_WRITE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                if (!cmd_reg[0]) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers; cmd_prev resets high so a COMMAND level held through reset is not an edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            cmd_prev_q   <= 1'b1;
            rx_base_q    <= '0;
            tx_base_q    <= '0;
            cnt_q        <= '0;
            lat_q        <= '0;
            mem_addr_q   <= '0;
            mem_din_q    <= '0;
            mem_we_q     <= '0;
            op_data_q    <= '0;
            op_valid_q   <= 1'b0;
            core_start_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cmd_prev_q   <= cmd_reg[0];
            rx_base_q    <= rx_base_d;
            tx_base_q    <= tx_base_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            mem_addr_q   <= mem_addr_d;
            mem_din_q    <= mem_din_d;
            mem_we_q     <= mem_we_d;
            op_data_q    <= op_data_d;
            op_valid_q   <= op_valid_d;
            core_start_q <= core_start_d;
        end
    end

    // STATUS is decoded straight from the state register
    always_comb begin
        status_reg           = '0;
        status_reg[DONE_BIT] = (state_q == S_DONE);
        status_reg[BUSY_BIT] = (state_q != S_IDLE) && (state_q != S_DONE);
    end

    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign mem_we     = mem_we_q;
    assign op_data    = op_data_q;
    assign op_valid   = op_valid_q;
    assign core_start = core_start_q;

endmodule

// File: tb/tb_ecdsa_cmd_ctrl.sv
// Directed bench for ecdsa_cmd_ctrl with a BRAM model (configurable read latency) and a core model.
// Latency: n/a.
// Backpressure: op_ready is driven per scenario.
module tb_ecdsa_cmd_ctrl;

    localparam int DATA_W = 1024;
    localparam int ADDR_W = 17;
    localparam int N_IN   = 4;
    localparam int RD_LAT = 2;

    logic                  clk = 1'b0;
    logic                  resetn;
    logic [31:0]           cmd_reg, rxaddr_reg, txaddr_reg, status_reg;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_din, mem_dout;
    logic [DATA_W/8-1:0]   mem_we;
    logic [DATA_W-1:0]     op_data;
    logic                  op_valid, op_ready;
    logic                  core_start, core_done;
    logic [DATA_W-1:0]     core_result;

    int n_cmp = 0;
    int n_err = 0;

    ecdsa_cmd_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .N_IN(N_IN), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .resetn(resetn), .cmd_reg(cmd_reg), .rxaddr_reg(rxaddr_reg),
        .txaddr_reg(txaddr_reg), .status_reg(status_reg), .mem_addr(mem_addr),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_we(mem_we), .op_data(op_data),
        .op_valid(op_valid), .op_ready(op_ready), .core_start(core_start),
        .core_done(core_done), .core_result(core_result)
    );

    always #5 clk = ~clk;

    // BRAM model: word-indexed, RD_LAT-stage read pipeline, full-word writes
    logic [DATA_W-1:0] mem [int];
    logic [DATA_W-1:0] rd_pipe [RD_LAT];
    int n_writes = 0;

    function automatic logic [DATA_W-1:0] mem_rd(input int idx);
        if (mem.exists(idx)) return mem[idx];
        return '0;
    endfunction

    always @(posedge clk) begin
        rd_pipe[0] <= mem_rd(int'(mem_addr >> 7));
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        if (mem_we != '0) begin
            n_writes <= n_writes + 1;
            if (mem_we == '1) mem[int'(mem_addr >> 7)] = mem_din;
        end
    end
    assign mem_dout = rd_pipe[RD_LAT-1];

    // Core model: result = sum of the operands of this command + 1, done 3 cycles after core_start
    logic [DATA_W-1:0] op_hist [$];
    logic [ADDR_W-1:0] addr_hist [$];
    logic [DATA_W-1:0] op_sum = '0;
    logic [DATA_W-1:0] model_result = '0;
    logic              model_done = 1'b0;
    int                model_cnt = 0;
    int                n_starts = 0;
    bit                core_auto = 1'b1;
    logic              tb_done = 1'b0;
    logic [DATA_W-1:0] tb_result = '0;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (op_valid && op_ready) begin
            op_hist.push_back(op_data);
            addr_hist.push_back(mem_addr);
            op_sum <= op_sum + op_data;
        end
        if (core_start) begin
            n_starts     <= n_starts + 1;
            model_result <= op_sum + 1;
            op_sum       <= '0;
            model_cnt    <= core_auto ? 3 : 0;
        end else if (model_cnt > 0) begin
            model_cnt <= model_cnt - 1;
            if (model_cnt == 1) model_done <= 1'b1;
        end
    end
    assign core_done   = model_done | tb_done;
    assign core_result = tb_done ? tb_result : model_result;

    task automatic wait_status(input logic [31:0] want, input int budget, output bit ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (status_reg == want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic start_cmd(input logic [31:0] rx, input logic [31:0] tx);
        @(negedge clk);
        rxaddr_reg = rx;
        txaddr_reg = tx;
        cmd_reg    = 32'h1;
    endtask

    task automatic test_reset;
        resetn = 1'b0; cmd_reg = 32'h1; rxaddr_reg = '0; txaddr_reg = '0; op_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (status_reg !== 32'h0) begin n_err++; $display("FAIL rst_status got %0h want 0", status_reg); end
        n_cmp++; if (mem_addr !== '0) begin n_err++; $display("FAIL rst_mem_addr got %0h want 0", mem_addr); end
        n_cmp++; if (mem_din !== '0) begin n_err++; $display("FAIL rst_mem_din got %0h want 0", mem_din); end
        n_cmp++; if (mem_we !== '0) begin n_err++; $display("FAIL rst_mem_we got %0h want 0", mem_we); end
        n_cmp++; if (op_data !== '0) begin n_err++; $display("FAIL rst_op_data got %0h want 0", op_data); end
        n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL rst_op_valid got %0b want 0", op_valid); end
        n_cmp++; if (core_start !== 1'b0) begin n_err++; $display("FAIL rst_core_start got %0b want 0", core_start); end
        // COMMAND held at 1 through reset must not start anything
        resetn = 1'b1;
        repeat (6) @(negedge clk);
        n_cmp++; if (status_reg !== 32'h0) begin n_err++; $display("FAIL rst_held_cmd status got %0h want 0", status_reg); end
        n_cmp++; if (n_starts !== 0) begin n_err++; $display("FAIL rst_held_cmd starts got %0d want 0", n_starts); end
        cmd_reg = 32'h0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int base_q, w0, s0;
        bit ok;
        for (int i = 0; i < 4; i++) mem[i] = DATA_W'(i + 1);
        base_q = op_hist.size(); w0 = n_writes; s0 = n_starts;
        start_cmd(32'h0, 32'h1000);
        @(negedge clk);
        n_cmp++; if (status_reg !== 32'h2) begin n_err++; $display("FAIL basic_busy status got %0h want 2", status_reg); end
        wait_status(32'h1, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_done status got %0h want 1", status_reg); end
        n_cmp++; if (mem_rd(32'h20) !== DATA_W'(11)) begin n_err++; $display("FAIL basic_result got %0h want b", mem_rd(32'h20)); end
        n_cmp++; if (n_writes - w0 !== 1) begin n_err++; $display("FAIL basic_writes got %0d want 1", n_writes - w0); end
        n_cmp++; if (n_starts - s0 !== 1) begin n_err++; $display("FAIL basic_starts got %0d want 1", n_starts - s0); end
        n_cmp++; if (op_hist.size() - base_q !== 4) begin n_err++; $display("FAIL basic_nops got %0d want 4", op_hist.size() - base_q); end
        for (int i = 0; i < 4 && base_q + i < op_hist.size(); i++) begin
            n_cmp++;
            if (op_hist[base_q+i] !== DATA_W'(i + 1)) begin
                n_err++; $display("FAIL basic_op%0d got %0h want %0h", i, op_hist[base_q+i], i + 1);
            end
        end
        @(negedge clk); cmd_reg = 32'h0;
        wait_status(32'h0, 2, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL basic_clear status got %0h want 0", status_reg); end
    endtask

    task automatic test_backpressure;
        logic [DATA_W-1:0] exp_op [4];
        logic [DATA_W-1:0] snap_d;
        logic [ADDR_W-1:0] exp_a;
        int base_q, w0, s0;
        bit ok;
        exp_op[0] = DATA_W'(32'hA); exp_op[1] = DATA_W'(32'hB);
        exp_op[2] = DATA_W'(32'hC); exp_op[3] = DATA_W'(32'hD);
        for (int i = 0; i < 4; i++) mem[2+i] = exp_op[i];
        base_q = op_hist.size(); w0 = n_writes; s0 = n_starts;
        op_ready = 1'b0;
        start_cmd(32'h105, 32'h2000);
        for (int w = 0; w < 4; w++) begin
            ok = 1'b0;
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                if (op_valid) begin ok = 1'b1; break; end
            end
            n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_valid%0d got 0 want 1", w); end
            exp_a = ADDR_W'(32'h100 + 32'h80 * w);
            n_cmp++; if (op_data !== exp_op[w]) begin n_err++; $display("FAIL bp_data%0d got %0h want %0h", w, op_data, exp_op[w]); end
            n_cmp++; if (mem_addr !== exp_a) begin n_err++; $display("FAIL bp_addr%0d got %0h want %0h", w, mem_addr, exp_a); end
            if (w == 0) begin
                // CSR changes mid-command must be ignored
                rxaddr_reg = 32'h7000; txaddr_reg = 32'h7800;
            end
            if (w == 1) begin
                snap_d = op_data;
                for (int c = 0; c < 5; c++) begin
                    @(negedge clk);
                    n_cmp++;
                    if (op_valid !== 1'b1 || op_data !== snap_d || mem_addr !== exp_a) begin
                        n_err++; $display("FAIL bp_stall%0d valid %0b data %0h addr %0h want 1 %0h %0h", c, op_valid, op_data, mem_addr, snap_d, exp_a);
                    end
                end
            end
            op_ready = 1'b1;
            @(negedge clk);
            op_ready = 1'b0;
            n_cmp++; if (op_valid !== 1'b0) begin n_err++; $display("FAIL bp_drop%0d got %0b want 0", w, op_valid); end
        end
        op_ready = 1'b1;
        wait_status(32'h1, 100, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_done status got %0h want 1", status_reg); end
        n_cmp++; if (op_hist.size() - base_q !== 4) begin n_err++; $display("FAIL bp_nops got %0d want 4", op_hist.size() - base_q); end
        n_cmp++; if (n_starts - s0 !== 1) begin n_err++; $display("FAIL bp_starts got %0d want 1", n_starts - s0); end
        n_cmp++; if (n_writes - w0 !== 1) begin n_err++; $display("FAIL bp_writes got %0d want 1", n_writes - w0); end
        n_cmp++; if (mem_rd(32'h40) !== DATA_W'(32'h2F)) begin n_err++; $display("FAIL bp_result got %0h want 2f", mem_rd(32'h40)); end
        @(negedge clk); cmd_reg = 32'h0;
        wait_status(32'h0, 2, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL bp_clear status got %0h want 0", status_reg); end
    endtask

    task automatic test_wrap;
        logic [ADDR_W-1:0] exp_a [4];
        logic [DATA_W-1:0] exp_op [4];
        int base_q;
        bit ok;
        exp_a[0] = 17'h1FF80; exp_a[1] = 17'h00000; exp_a[2] = 17'h00080; exp_a[3] = 17'h00100;
        exp_op[0] = DATA_W'(32'h11); exp_op[1] = DATA_W'(32'h22);
        exp_op[2] = DATA_W'(32'h33); exp_op[3] = DATA_W'(32'h44);
        mem[32'h3FF] = exp_op[0]; mem[0] = exp_op[1]; mem[1] = exp_op[2]; mem[2] = exp_op[3];
        base_q = op_hist.size();
        start_cmd(32'h1FF85, 32'h3000);
        wait_status(32'h1, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL wrap_done status got %0h want 1", status_reg); end
        n_cmp++; if (op_hist.size() - base_q !== 4) begin n_err++; $display("FAIL wrap_nops got %0d want 4", op_hist.size() - base_q); end
        for (int i = 0; i < 4 && base_q + i < op_hist.size(); i++) begin
            n_cmp++;
            if (addr_hist[base_q+i] !== exp_a[i] || op_hist[base_q+i] !== exp_op[i]) begin
                n_err++; $display("FAIL wrap_rd%0d addr %0h data %0h want %0h %0h", i, addr_hist[base_q+i], op_hist[base_q+i], exp_a[i], exp_op[i]);
            end
        end
        n_cmp++; if (mem_rd(32'h60) !== DATA_W'(32'hAB)) begin n_err++; $display("FAIL wrap_result got %0h want ab", mem_rd(32'h60)); end
    endtask

    task automatic test_held_cmd;
        int w0, s0;
        bit ok;
        w0 = n_writes; s0 = n_starts;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_cmp++; if (status_reg !== 32'h1) begin n_err++; $display("FAIL held_status%0d got %0h want 1", c, status_reg); end
        end
        // A stray core_done outside WAIT_CORE must not write anything
        tb_result = DATA_W'(32'hDEAD);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (n_writes !== w0) begin n_err++; $display("FAIL held_stray_write got %0d want %0d", n_writes, w0); end
        n_cmp++; if (n_starts !== s0) begin n_err++; $display("FAIL held_restart got %0d want %0d", n_starts, s0); end
        n_cmp++; if (status_reg !== 32'h1) begin n_err++; $display("FAIL held_status_end got %0h want 1", status_reg); end
        cmd_reg = 32'h0;
        start_cmd(32'h1FF85, 32'h3800);
        wait_status(32'h1, 200, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL held_second_done status got %0h want 1", status_reg); end
        n_cmp++; if (n_starts - s0 !== 1) begin n_err++; $display("FAIL held_second_starts got %0d want 1", n_starts - s0); end
        n_cmp++; if (mem_rd(32'h70) !== DATA_W'(32'hAB)) begin n_err++; $display("FAIL held_second_result got %0h want ab", mem_rd(32'h70)); end
        @(negedge clk); cmd_reg = 32'h0;
        wait_status(32'h0, 2, ok);
        n_cmp++; if (!ok) begin n_err++; $display("FAIL held_clear status got %0h want 0", status_reg); end
    endtask

    task automatic test_reset_mid;
        int w0, s0;
        bit ok;
        core_auto = 1'b0;
        w0 = n_writes; s0 = n_starts;
        start_cmd(32'h0, 32'h5000);
        ok = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (n_starts != s0) begin ok = 1'b1; break; end
        end
        n_cmp++; if (!ok) begin n_err++; $display("FAIL rmid_start got %0d starts want 1", n_starts - s0); end
        repeat (2) @(negedge clk);
        n_cmp++; if (status_reg !== 32'h2) begin n_err++; $display("FAIL rmid_busy got %0h want 2", status_reg); end
        resetn = 1'b0;
        #1;
        n_cmp++; if (status_reg !== 32'h0) begin n_err++; $display("FAIL rmid_status got %0h want 0", status_reg); end
        n_cmp++; if (mem_addr !== '0 || mem_we !== '0 || op_valid !== 1'b0 || core_start !== 1'b0) begin
            n_err++; $display("FAIL rmid_ctl addr %0h we %0h valid %0b start %0b want 0", mem_addr, mem_we, op_valid, core_start);
        end
        n_cmp++; if (mem_din !== '0 || op_data !== '0) begin
            n_err++; $display("FAIL rmid_data din %0h op %0h want 0", mem_din, op_data);
        end
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        tb_result = DATA_W'(32'h55);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        repeat (8) @(negedge clk);
        n_cmp++; if (n_writes !== w0) begin n_err++; $display("FAIL rmid_writes got %0d want %0d", n_writes, w0); end
        n_cmp++; if (mem_rd(32'hA0) !== '0) begin n_err++; $display("FAIL rmid_mem got %0h want 0", mem_rd(32'hA0)); end
        n_cmp++; if (status_reg !== 32'h0) begin n_err++; $display("FAIL rmid_status_end got %0h want 0", status_reg); end
        n_cmp++; if (n_starts - s0 !== 1) begin n_err++; $display("FAIL rmid_starts got %0d want 1", n_starts - s0); end
        cmd_reg = 32'h0;
        core_auto = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_wrap();
        test_held_cmd();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
